// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl
//
// Time-entry front end for the stopwatch/clock. Two raw buttons (add/sub) are
// synchronised and debounced. While exactly one is held, the selected time field
// is stepped once immediately. After REPEAT_DELAY cycles it auto-repeats every
// REPEAT_RATE cycles. Each field wraps inside its own range without carry.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ms_sw/s_sw/min_sw/hr_sw  field select, priority ms > s > min > hr
//   add_time, sub_time    raw asynchronous buttons
//   clr                   synchronous clear of all fields (wins over a step)
//   ms_o/sec_o/min_o/hr_o registered field values
//   step_o                one-cycle pulse per applied step (suppressed by clr)

module time_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned MS_MAX          = 999,
  parameter int unsigned SEC_MAX         = 59,
  parameter int unsigned MIN_MAX         = 59,
  parameter int unsigned HR_MAX          = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_sw,
  input  logic       s_sw,
  input  logic       min_sw,
  input  logic       hr_sw,
  input  logic       add_time,
  input  logic       sub_time,
  input  logic       clr,
  output logic [9:0] ms_o,
  output logic [5:0] sec_o,
  output logic [5:0] min_o,
  output logic [4:0] hr_o,
  output logic       step_o
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CntTop = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CntW   = $clog2(CntTop + 1);

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

  localparam logic [9:0] MsMax  = 10'(MS_MAX);
  localparam logic [5:0] SecMax = 6'(SEC_MAX);
  localparam logic [5:0] MinMax = 6'(MIN_MAX);
  localparam logic [4:0] HrMax  = 5'(HR_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } state_e;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers. Bit 0 = add, bit 1 = sub.
  // ---------------------------------------------------------------------------
  logic [1:0]          sync1_q;
  logic [1:0]          sync2_q;
  logic [1:0]          db_q;
  logic [1:0][DbW-1:0] db_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= {sub_time, add_time};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the accepted level.
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic dir_up;
  logic dir_dn;
  logic dir_act;

  assign dir_up  = db_q[0] & ~db_q[1];
  assign dir_dn  = db_q[1] & ~db_q[0];
  assign dir_act = dir_up | dir_dn;

  // ---------------------------------------------------------------------------
  // Step / auto-repeat sequencer
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_up_q;   // direction of the most recent step
  logic            step_req;
  logic            reversed;

  // A reversal is a jump straight to the opposite non-zero direction.
  assign reversed = dir_act & (dir_up != last_up_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_req = 1'b0;
    case (state_q)
      StIdle: begin
        if (dir_act) begin
          step_req = 1'b1;
          cnt_d    = '0;
          state_d  = StDelay;
        end
      end
      StDelay: begin
        if (!dir_act) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (reversed) begin
          step_req = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == DelayLast) begin
          step_req = 1'b1;
          cnt_d    = '0;
          state_d  = StRepeat;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRepeat: begin
        if (!dir_act) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (reversed) begin
          // Reversal restarts the initial hold delay in the new direction.
          step_req = 1'b1;
          cnt_d    = '0;
          state_d  = StDelay;
        end else if (cnt_q == RateLast) begin
          step_req = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Field select and wrapped next values
  // ---------------------------------------------------------------------------
  logic sel_ms, sel_sec, sel_min, sel_hr;

  assign sel_ms  = ms_sw;
  assign sel_sec = ~ms_sw & s_sw;
  assign sel_min = ~ms_sw & ~s_sw & min_sw;
  assign sel_hr  = ~ms_sw & ~s_sw & ~min_sw & hr_sw;

  logic [9:0] ms_q, ms_step;
  logic [5:0] sec_q, sec_step;
  logic [5:0] min_q, min_step;
  logic [4:0] hr_q, hr_step;
  logic       step_q;

  always_comb begin
    if (dir_up) begin
      ms_step  = (ms_q == MsMax)   ? '0 : ms_q + 10'd1;
      sec_step = (sec_q == SecMax) ? '0 : sec_q + 6'd1;
      min_step = (min_q == MinMax) ? '0 : min_q + 6'd1;
      hr_step  = (hr_q == HrMax)   ? '0 : hr_q + 5'd1;
    end else begin
      ms_step  = (ms_q == '0)  ? MsMax  : ms_q - 10'd1;
      sec_step = (sec_q == '0) ? SecMax : sec_q - 6'd1;
      min_step = (min_q == '0) ? MinMax : min_q - 6'd1;
      hr_step  = (hr_q == '0)  ? HrMax  : hr_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_up_q <= 1'b0;
      step_q    <= 1'b0;
      ms_q      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
    end else begin
      // Sequencer keeps running through clr so repeat timing is undisturbed.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (step_req) begin
        last_up_q <= dir_up;
      end
      step_q <= step_req & ~clr;
      if (clr) begin
        ms_q  <= '0;
        sec_q <= '0;
        min_q <= '0;
        hr_q  <= '0;
      end else if (step_req) begin
        if (sel_ms)  ms_q  <= ms_step;
        if (sel_sec) sec_q <= sec_step;
        if (sel_min) min_q <= min_step;
        if (sel_hr)  hr_q  <= hr_step;
      end
    end
  end

  assign ms_o   = ms_q;
  assign sec_o  = sec_q;
  assign min_o  = min_q;
  assign hr_o   = hr_q;
  assign step_o = step_q;

endmodule
